// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed hex seven-segment driver with tear-free load, dp, blanking, PWM
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   load            single-cycle strobe capturing value/dp_in into the shadow register
//   value           NUM_DIGITS hex nibbles, digit 0 in bits [3:0] (rightmost)
//   dp_in           per-digit decimal point request, 1 = lit
//   blank_lz        1 = suppress leading zero digits (sampled live)
//   brightness      PWM duty, 0 = dark, all-ones = full on (sampled live)
//   segments        active-low {g,f,e,d,c,b,a}
//   dp              active-low decimal point
//   anode           active-low digit enables, one-hot-low or all-high
//   update_pending  shadow holds a load not yet committed
//   frame_done      one-cycle pulse per frame boundary
module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 25000,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    update_pending,
    output logic                    frame_done
);

    localparam int DSEL_W = $clog2(NUM_DIGITS);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DSEL_W-1:0] DSEL_LAST = DSEL_W'(NUM_DIGITS - 1);

    logic [SCAN_W-1:0]       scan_cnt;
    logic [DSEL_W-1:0]       digit_sel;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              nibble;
    logic                    sel_dp;
    logic                    sel_lz;
    logic                    zero_run;
    logic                    pwm_on;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   anode_next;

    assign slot_end  = (scan_cnt == SCAN_LAST);
    assign frame_end = slot_end && (digit_sel == DSEL_LAST);
    assign pwm_on    = (&brightness) || (pwm_cnt < brightness);

    // Walk digits from the most significant down; zero_run stays set while
    // every nibble from the top down to digit i is zero, which is exactly the
    // leading-zero condition for digit i.
    always_comb begin
        nibble     = 4'h0;
        sel_dp     = 1'b0;
        sel_lz     = 1'b0;
        zero_run   = 1'b1;
        anode_next = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_val[4*i +: 4] == 4'h0);
            if (DSEL_W'(i) == digit_sel) begin
                nibble = disp_val[4*i +: 4];
                sel_dp = disp_dp[i];
                sel_lz = (i != 0) && zero_run;
                // First cycle of each slot stays dark so the previous digit
                // never ghosts onto the newly selected anode.
                if (scan_cnt != '0 && pwm_on) begin
                    anode_next[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        seg_next = 7'h7F;
        case (nibble)
            4'h0: seg_next = 7'h40;
            4'h1: seg_next = 7'h79;
            4'h2: seg_next = 7'h24;
            4'h3: seg_next = 7'h30;
            4'h4: seg_next = 7'h19;
            4'h5: seg_next = 7'h12;
            4'h6: seg_next = 7'h02;
            4'h7: seg_next = 7'h78;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h10;
            4'hA: seg_next = 7'h08;
            4'hB: seg_next = 7'h03;
            4'hC: seg_next = 7'h46;
            4'hD: seg_next = 7'h21;
            4'hE: seg_next = 7'h06;
            4'hF: seg_next = 7'h0E;
            default: seg_next = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt       <= '0;
            digit_sel      <= '0;
            pwm_cnt        <= '0;
            shadow_val     <= '0;
            shadow_dp      <= '0;
            disp_val       <= '0;
            disp_dp        <= '0;
            update_pending <= 1'b0;
            frame_done     <= 1'b0;
            segments       <= 7'h7F;
            dp             <= 1'b1;
            anode          <= '1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;

            if (slot_end) begin
                scan_cnt  <= '0;
                digit_sel <= frame_end ? '0 : digit_sel + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            frame_done <= frame_end;

            // A load landing on the boundary itself bypasses the shadow so it
            // is neither lost nor delayed by a whole frame.
            if (load && frame_end) begin
                disp_val       <= value;
                disp_dp        <= dp_in;
                update_pending <= 1'b0;
            end else if (load) begin
                shadow_val     <= value;
                shadow_dp      <= dp_in;
                update_pending <= 1'b1;
            end else if (frame_end && update_pending) begin
                disp_val       <= shadow_val;
                disp_dp        <= shadow_dp;
                update_pending <= 1'b0;
            end

            segments <= (blank_lz && sel_lz) ? 7'h7F : seg_next;
            dp       <= ~sel_dp;
            anode    <= anode_next;
        end
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised successor to the fixed 4-digit seven-segment driver.
- Time-multiplexes NUM_DIGITS hex digits onto one shared active-low segment bus.
- Adds these behaviours:
  - double-buffered, tear-free value loading, committed only at frame boundaries;
  - per-digit decimal points;
  - optional leading-zero blanking;
  - PWM brightness control.
- Sits between the acoustics datapath or status logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits and anode lines (2..8).
- SCAN_DIV, 25000, clk cycles each digit stays selected (at least 2).
- BRIGHT_W, 4, width of the brightness control and PWM counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures value and dp_in
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- blank_lz  in  1  1 = suppress leading zero digits
- brightness  in  BRIGHT_W  0 = dark; all-ones = full on
- segments  out  7  active-low segments {g,f,e,d,c,b,a}, same bitmap as the existing driver
- dp  out  1  active-low decimal point
- anode  out  NUM_DIGITS  active-low digit enables, one-hot-low or all-high
- update_pending  out  1  shadow register holds an uncommitted load
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- All state and outputs are registered.
- Reset values:
  - segments = 7'h7F, dp = 1, anode = all ones;
  - update_pending = 0, frame_done = 0;
  - scan_cnt, digit_sel, pwm_cnt, display register, shadow register all 0.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and digit_sel increments.
  - digit_sel wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle where scan_cnt == SCAN_DIV-1 and digit_sel == NUM_DIGITS-1.
- Load:
  - load=1 writes {value, dp_in} into the shadow register and sets update_pending.
  - A further load while pending overwrites the shadow; last write wins.
- Commit at a frame boundary:
  - If update_pending, the shadow copies into the display register, update_pending clears, and frame_done pulses.
  - frame_done pulses on every boundary, pending or not.
  - Load on the boundary cycle itself: incoming value and dp_in commit directly to the display register; update_pending stays 0.
- Output formation for the selected digit d:
  - nibble = display[4d+3:4d]; segments = hex bitmap of nibble; dp = ~display_dp[d].
  - Outputs are registered one cycle after the scan state (latency 1).
- Leading-zero blanking (blank_lz = 1):
  - Digit d > 0 is blanked when nibbles d..NUM_DIGITS-1 of the display register are all zero.
  - A blanked digit drives segments = 7'h7F. Its dp still follows display_dp[d], and its anode still follows PWM.
  - Digit 0 is never blanked, so value 0 shows "0".
  - blank_lz is sampled live, not buffered.
- Ghost guard: anode is all ones on the first output cycle of every digit slot (registered scan_cnt == 0).
- PWM:
  - pwm_cnt is a free-running BRIGHT_W-bit counter that wraps.
  - Anode d is driven low when all of the following hold: the ghost guard is inactive; brightness is all-ones or pwm_cnt < brightness; d is the selected digit.
  - brightness = 0 gives anode all ones permanently. Segments keep updating regardless.
  - brightness is sampled live.
- Reset mid-frame: everything returns to reset values immediately. Any pending shadow content is discarded.
- Widths: digit_sel is $clog2(NUM_DIGITS) bits; scan_cnt is $clog2(SCAN_DIV) bits; no overflow beyond the wraps defined above.

Test Plan:
- Reset/scan: NUM_DIGITS=4, SCAN_DIV=4, brightness=4'hF; release rst_n -> anode sequence 1111, then 1110 for 3 cycles, 1111, 1101 for 3 cycles, and so on, wrapping after digit 3; frame_done pulses every 16 cycles.
- Tear-free load: load value=16'h1234 mid-frame -> update_pending=1; display keeps the old value until the boundary; next frame shows 4,3,2,1 on digits 0..3; update_pending=0; frame_done pulses on the commit cycle.
- Overwrite and boundary collision: load 16'hAAAA then 16'h00B5 in the same frame -> only 00B5 is shown. A load of 16'h7777 exactly on the boundary cycle -> 7777 shown in the next frame, and update_pending never rises.
- Leading-zero blanking: value=16'h00B5, blank_lz=1 -> digits 3 and 2 segments = 7'h7F, digit 1 = B (7'b000_0011), digit 0 = 5. value=0 -> only digit 0 shows ZERO. dp_in=4'b0100 -> dp low during digit 2 even though digit 2 is blanked.
- Brightness: brightness=4 -> within a slot, anode low only while pwm_cnt < 4 (4/16 duty, checked over a long SCAN_DIV); brightness=0 -> anode stays 1111; brightness=4'hF -> low for the whole slot except the guard cycle.
- Async reset: assert rst_n low mid-frame with load pending -> outputs reach reset values with no clock edge; after release, update_pending=0 and the display shows 0.
